sd_resp_rx: RTL

Command-line response receiver for the SD host controller; it is the stage directly downstream of the command sender. After a command token has gone out on `sd_cmd`, the controller arms this block. It then waits for the card's start bit, shifts in a 48-bit short or 136-bit long (R2) response, and checks the CRC7, the transmission bit and the end bit. It reports the payload and status to the controller FSM with a single-cycle valid pulse, and signals a timeout if the card never answers.

---
 rtl/sd_resp_if.sv | 28 ++
 rtl/sd_resp_rx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sd_resp_if.sv
// Bus between the SD host controller FSM and the CMD-line response receiver.
// Handshake: the controller may pulse rx_en at any time, but it is accepted only
// while busy=0. Completion is a one-cycle resp_valid with no back-pressure.
// Payload and flags are stable from resp_valid until the next accepted rx_en.
interface sd_resp_if;
    logic         rx_en;
    logic         resp_long;
    logic         crc_check;
    logic         sd_cmd;
    logic         busy;
    logic         resp_valid;
    logic [127:0] resp_data;
    logic         crc_err;
    logic         end_err;
    logic         dir_err;
    logic         timeout;
    logic [1:0]   dbg_state;

    modport master (
        output rx_en, resp_long, crc_check, sd_cmd,
        input  busy, resp_valid, resp_data, crc_err, end_err, dir_err, timeout, dbg_state
    );

    modport slave (
        input  rx_en, resp_long, crc_check, sd_cmd,
        output busy, resp_valid, resp_data, crc_err, end_err, dir_err, timeout, dbg_state
    );
endinterface

// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: start-bit wait with timeout, 48/136-bit shift-in,
// CRC7, transmission-bit and end-bit checks. Define SD_RESP_LONG_EN for R2 support.
module sd_resp_rx #(
    parameter int NCR_MAX = 64
) (
    input logic     sd_clk,
    input logic     reset_n,
    sd_resp_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RECV = 2'd2;
    localparam logic [6:0] CRC_POLY = 7'h09;
    localparam int WW = $clog2(NCR_MAX + 1);
`ifdef SD_RESP_LONG_EN
    localparam int SW = 128;
`else
    localparam int SW = 48;
`endif

    logic [1:0]    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [7:0]    bit_q, bit_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [6:0]    crc_q, crc_d;
    logic          long_q, long_d;
    logic          chk_q, chk_d;
    logic          dir_bad_q, dir_bad_d;
    logic          crc_bad_q, crc_bad_d;
    logic          valid_q, valid_d;
    logic [127:0]  data_q, data_d;
    logic          crc_err_q, crc_err_d;
    logic          end_err_q, end_err_d;
    logic          dir_err_q, dir_err_d;
    logic          timeout_q, timeout_d;

    logic          long_arm;
    logic [7:0]    last_bit, crc_lo, crc_hi, bit_n;
    logic [6:0]    crc_next;
    logic [127:0]  payload;
    logic          unused_shift;

`ifdef SD_RESP_LONG_EN
    assign long_arm = bus.resp_long;
    assign payload  = long_q ? {shift_q[126:0], 1'b0} : {90'b0, shift_q[44:7]};
`else
    logic unused_resp_long;
    assign unused_resp_long = bus.resp_long;
    assign long_arm = 1'b0;
    assign payload  = {90'b0, shift_q[44:7]};
`endif
    assign unused_shift = ^{shift_q[SW-1:45], shift_q[6]};

    // Bit numbers count from 1 at the start bit; CRC covers bits crc_lo..crc_hi
    // and the 7-bit CRC field sits just before the end bit.
    assign last_bit = long_q ? 8'd136 : 8'd48;
    assign crc_lo   = long_q ? 8'd9 : 8'd1;
    assign crc_hi   = last_bit - 8'd8;
    assign bit_n    = bit_q + 8'd1;
    assign crc_next = {crc_q[5:0], 1'b0} ^ ((crc_q[6] ^ bus.sd_cmd) ? CRC_POLY : 7'h00);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        crc_d     = crc_q;
        long_d    = long_q;
        chk_d     = chk_q;
        dir_bad_d = dir_bad_q;
        crc_bad_d = crc_bad_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        crc_err_d = crc_err_q;
        end_err_d = end_err_q;
        dir_err_d = dir_err_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.rx_en) begin
                    long_d    = long_arm;
                    chk_d     = bus.crc_check;
                    data_d    = '0;
                    crc_err_d = 1'b0;
                    end_err_d = 1'b0;
                    dir_err_d = 1'b0;
                    timeout_d = 1'b0;
                    dir_bad_d = 1'b0;
                    crc_bad_d = 1'b0;
                    crc_d     = '0;
                    wait_d    = '0;
                    bit_d     = '0;
                    shift_d   = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.sd_cmd) begin
                    bit_d   = 8'd1;
                    shift_d = {shift_q[SW-2:0], bus.sd_cmd};
                    if (crc_lo == 8'd1) crc_d = crc_next;
                    state_d = S_RECV;
                end else if (wait_q == WW'(NCR_MAX - 1)) begin
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_RECV: begin
                bit_d   = bit_n;
                shift_d = {shift_q[SW-2:0], bus.sd_cmd};
                if (bit_n >= crc_lo && bit_n <= crc_hi) crc_d = crc_next;
                if (bit_n == 8'd2) dir_bad_d = bus.sd_cmd;
                if (bit_n == last_bit - 8'd1) crc_bad_d = ({shift_q[5:0], bus.sd_cmd} != crc_q);
                // The end bit completes the frame; results publish together with resp_valid.
                if (bit_n == last_bit) begin
                    end_err_d = ~bus.sd_cmd;
                    dir_err_d = dir_bad_q;
                    crc_err_d = crc_bad_q & chk_q;
                    data_d    = payload;
                    valid_d   = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sd_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            crc_q     <= '0;
            long_q    <= 1'b0;
            chk_q     <= 1'b0;
            dir_bad_q <= 1'b0;
            crc_bad_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            dir_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            long_q    <= long_d;
            chk_q     <= chk_d;
            dir_bad_q <= dir_bad_d;
            crc_bad_q <= crc_bad_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            crc_err_q <= crc_err_d;
            end_err_q <= end_err_d;
            dir_err_q <= dir_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.resp_valid = valid_q;
    assign bus.resp_data  = data_q;
    assign bus.crc_err    = crc_err_q;
    assign bus.end_err    = end_err_q;
    assign bus.dir_err    = dir_err_q;
    assign bus.timeout    = timeout_q;
    assign bus.dbg_state  = state_q;
endmodule
